// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_arbiter
// Purpose  : Shares the RAM_word array between the SUBLEQ core and the loader,
//            sequencing reads and glitch-free store strobes on the shared bus.
// Revision : 1.0
// ============================================================================
module ram_access_arbiter #(
    parameter int WORD_LENGTH     = 16,
    parameter int ADDR_LENGTH     = 16,
    parameter bit LOADER_PRIORITY = 1'b0
) (
    input  logic                   CLK,
    input  logic                   bar_RST,
    input  logic                   CORE_REQ,
    input  logic                   CORE_WE,
    input  logic [ADDR_LENGTH-1:0] CORE_ADDR,
    input  logic [WORD_LENGTH-1:0] CORE_WDATA,
    output logic                   CORE_ACK,
    output logic [WORD_LENGTH-1:0] CORE_RDATA,
    output logic                   CORE_ERR,
    input  logic                   LDR_REQ,
    input  logic                   LDR_WE,
    input  logic [ADDR_LENGTH-1:0] LDR_ADDR,
    input  logic [WORD_LENGTH-1:0] LDR_WDATA,
    output logic                   LDR_ACK,
    output logic [WORD_LENGTH-1:0] LDR_RDATA,
    output logic                   LDR_ERR,
    output logic [ADDR_LENGTH-1:0] MEM_ADDR,
    output logic [WORD_LENGTH-1:0] MEM_WDATA,
    output logic                   MEM_STORE,
    input  logic [WORD_LENGTH-1:0] MEM_RDATA,
    input  logic                   MEM_RVALID,
    output logic                   BUSY
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD        = 3'd1,
        S_WR_SETUP  = 3'd2,
        S_WR_STROBE = 3'd3,
        S_WR_HOLD   = 3'd4,
        S_ACK       = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_grant_ldr;
    logic                   r_last_ldr;
    logic                   r_err;
    logic                   r_store;
    logic [ADDR_LENGTH-1:0] r_addr;
    logic [WORD_LENGTH-1:0] r_wdata;
    logic [WORD_LENGTH-1:0] r_core_rdata;
    logic [WORD_LENGTH-1:0] r_ldr_rdata;

    logic                   w_any_req;
    logic                   w_grant_ldr;
    logic                   w_sel_we;
    logic                   w_ack;

    // Round-robin favours whoever was not granted last; the pointer moves on every grant.
    always_comb begin
        w_any_req   = CORE_REQ | LDR_REQ;
        w_grant_ldr = LDR_REQ;
        if (CORE_REQ && LDR_REQ) begin
            w_grant_ldr = LOADER_PRIORITY ? 1'b1 : ~r_last_ldr;
        end
        w_sel_we = w_grant_ldr ? LDR_WE : CORE_WE;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = w_sel_we ? S_WR_SETUP : S_RD;
                end
            end
            S_RD:        w_state_next = S_ACK;
            S_WR_SETUP:  w_state_next = MEM_RVALID ? S_WR_STROBE : S_ACK;
            S_WR_STROBE: w_state_next = S_WR_HOLD;
            S_WR_HOLD:   w_state_next = S_ACK;
            S_ACK:       w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge bar_RST) begin
        if (!bar_RST) begin
            r_state      <= S_IDLE;
            r_grant_ldr  <= 1'b0;
            r_last_ldr   <= 1'b1;
            r_err        <= 1'b0;
            r_store      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core_rdata <= '0;
            r_ldr_rdata  <= '0;
        end else begin
            r_state <= w_state_next;
            // Strobe is a flop so it cannot glitch; address/data were latched a cycle earlier.
            r_store <= (w_state_next == S_WR_STROBE);
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_ldr <= w_grant_ldr;
                        r_last_ldr  <= w_grant_ldr;
                        r_addr      <= w_grant_ldr ? LDR_ADDR : CORE_ADDR;
                        r_wdata     <= w_grant_ldr ? LDR_WDATA : CORE_WDATA;
                        r_err       <= 1'b0;
                    end
                end
                S_RD: begin
                    r_err <= ~MEM_RVALID;
                    if (r_grant_ldr) begin
                        r_ldr_rdata <= MEM_RVALID ? MEM_RDATA : '0;
                    end else begin
                        r_core_rdata <= MEM_RVALID ? MEM_RDATA : '0;
                    end
                end
                S_WR_SETUP: r_err <= ~MEM_RVALID;
                default: ;
            endcase
        end
    end

    assign w_ack      = (r_state == S_ACK);
    assign CORE_ACK   = w_ack & ~r_grant_ldr;
    assign LDR_ACK    = w_ack & r_grant_ldr;
    assign CORE_ERR   = CORE_ACK & r_err;
    assign LDR_ERR    = LDR_ACK & r_err;
    assign CORE_RDATA = r_core_rdata;
    assign LDR_RDATA  = r_ldr_rdata;
    assign MEM_ADDR   = r_addr;
    assign MEM_WDATA  = r_wdata;
    assign MEM_STORE  = r_store;
    assign BUSY       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_access_arbiter
// Purpose  : Scoreboard bench for ram_access_arbiter with a 16-word RAM model.
// Revision : 1.0
// ============================================================================
module tb_ram_access_arbiter;

    logic clk;
    logic bar_rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    logic        c0_req, c0_we, c0_ack, c0_err, l0_req, l0_we, l0_ack, l0_err;
    logic [15:0] c0_addr, c0_wdata, c0_rdata, l0_addr, l0_wdata, l0_rdata;
    logic [15:0] m0_addr, m0_wdata, m0_rdata;
    logic        m0_store, m0_rvalid, busy0;

    logic        c1_req, c1_we, c1_ack, c1_err, l1_req, l1_we, l1_ack, l1_err;
    logic [15:0] c1_addr, c1_wdata, c1_rdata, l1_addr, l1_wdata, l1_rdata;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_store, m1_rvalid, busy1;

    logic [15:0] mem [0:15];

    typedef struct {
        logic        ldr;
        logic [15:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    logic [15:0] hold_core, hold_ldr;
    logic        chk_store = 1'b1;
    logic        p_store   = 1'b0;
    logic [15:0] p_addr    = '0;
    logic [15:0] p_wdata   = '0;
    int          st_len    = 0;
    int          n_store   = 0;
    logic [15:0] st_addr   = '0;
    logic [15:0] st_wdata  = '0;

    ram_access_arbiter #(.WORD_LENGTH(16), .ADDR_LENGTH(16), .LOADER_PRIORITY(1'b0)) d0 (
        .CLK(clk), .bar_RST(bar_rst),
        .CORE_REQ(c0_req), .CORE_WE(c0_we), .CORE_ADDR(c0_addr), .CORE_WDATA(c0_wdata),
        .CORE_ACK(c0_ack), .CORE_RDATA(c0_rdata), .CORE_ERR(c0_err),
        .LDR_REQ(l0_req), .LDR_WE(l0_we), .LDR_ADDR(l0_addr), .LDR_WDATA(l0_wdata),
        .LDR_ACK(l0_ack), .LDR_RDATA(l0_rdata), .LDR_ERR(l0_err),
        .MEM_ADDR(m0_addr), .MEM_WDATA(m0_wdata), .MEM_STORE(m0_store),
        .MEM_RDATA(m0_rdata), .MEM_RVALID(m0_rvalid), .BUSY(busy0)
    );

    ram_access_arbiter #(.WORD_LENGTH(16), .ADDR_LENGTH(16), .LOADER_PRIORITY(1'b1)) d1 (
        .CLK(clk), .bar_RST(bar_rst),
        .CORE_REQ(c1_req), .CORE_WE(c1_we), .CORE_ADDR(c1_addr), .CORE_WDATA(c1_wdata),
        .CORE_ACK(c1_ack), .CORE_RDATA(c1_rdata), .CORE_ERR(c1_err),
        .LDR_REQ(l1_req), .LDR_WE(l1_we), .LDR_ADDR(l1_addr), .LDR_WDATA(l1_wdata),
        .LDR_ACK(l1_ack), .LDR_RDATA(l1_rdata), .LDR_ERR(l1_err),
        .MEM_ADDR(m1_addr), .MEM_WDATA(m1_wdata), .MEM_STORE(m1_store),
        .MEM_RDATA(m1_rdata), .MEM_RVALID(m1_rvalid), .BUSY(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: words 0x0000-0x000F exist; unmapped reads present junk to prove it is masked.
    assign m0_rvalid = (m0_addr[15:4] == 12'h000);
    assign m0_rdata  = m0_rvalid ? mem[m0_addr[3:0]] : 16'hDEAD;
    assign m1_rvalid = (m1_addr[15:4] == 12'h000);
    assign m1_rdata  = m1_rvalid ? mem[m1_addr[3:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (m0_store && m0_rvalid) mem[m0_addr[3:0]] <= m0_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic ldr, input logic [15:0] rd, input logic err, input int c);
        exp_t e;
        e.ldr = ldr; e.rdata = rd; e.err = err; e.cyc = c;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic check_ack(input int d, input logic ca, input logic la, input logic ce,
                             input logic le, input logic [15:0] cr, input logic [15:0] lr);
        exp_t        e;
        logic [15:0] rd;
        logic        er;
        if (!ca && !la) return;
        total++;
        if (ca && la) begin
            bad++;
            $display("FAIL dut%0d dual_ack: got both ACKs want one", d);
            return;
        end
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            bad++;
            $display("FAIL dut%0d unexpected_ack: got ack ldr=%0d at cyc %0d want none", d, la, cyc);
            return;
        end
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        rd = la ? lr : cr;
        er = la ? le : ce;
        if (la !== e.ldr || rd !== e.rdata || er !== e.err || (e.cyc >= 0 && cyc != e.cyc)) begin
            bad++;
            $display("FAIL dut%0d ack: got ldr=%0d rdata=%h err=%0d cyc=%0d want ldr=%0d rdata=%h err=%0d cyc=%0d",
                     d, la, rd, er, cyc, e.ldr, e.rdata, e.err, e.cyc);
        end
    endtask

    always @(negedge clk) check_ack(0, c0_ack, l0_ack, c0_err, l0_err, c0_rdata, l0_rdata);
    always @(negedge clk) check_ack(1, c1_ack, l1_ack, c1_err, l1_err, c1_rdata, l1_rdata);

    // Store strobe must be one cycle wide with address/data stable on both sides of it.
    always @(negedge clk) begin
        if (chk_store) begin
            if (m0_store && !p_store) begin
                total++;
                if (m0_addr !== p_addr || m0_wdata !== p_wdata) begin
                    bad++;
                    $display("FAIL store_setup: got %h/%h want %h/%h", m0_addr, m0_wdata, p_addr, p_wdata);
                end
                n_store++;
                st_addr  = m0_addr;
                st_wdata = m0_wdata;
            end
            if (!m0_store && p_store) begin
                total++;
                if (m0_addr !== p_addr || m0_wdata !== p_wdata || st_len != 1) begin
                    bad++;
                    $display("FAIL store_hold: got %h/%h len=%0d want %h/%h len=1",
                             m0_addr, m0_wdata, st_len, p_addr, p_wdata);
                end
            end
        end
        st_len  = m0_store ? st_len + 1 : 0;
        p_store = m0_store;
        p_addr  = m0_addr;
        p_wdata = m0_wdata;
    end

    task automatic wait_acks(input int d, input int n);
        int got = 0;
        for (int i = 0; i < 60 && got < n; i++) begin
            @(negedge clk);
            if (d == 0 && (c0_ack || l0_ack)) got++;
            if (d == 1 && (c1_ack || l1_ack)) got++;
        end
        if (got < n) begin
            total++;
            bad++;
            $display("FAIL dut%0d ack_timeout: got %0d acks want %0d", d, got, n);
        end
    endtask

    // One transaction on dut0; called from the IDLE-side negedge so latency is exact.
    task automatic single(input logic ldr, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rd, input logic err, input int lat);
        logic [15:0] exp_rd;
        @(negedge clk);
        if (ldr) begin
            l0_we = we; l0_addr = addr; l0_wdata = wdata; l0_req = 1'b1;
        end else begin
            c0_we = we; c0_addr = addr; c0_wdata = wdata; c0_req = 1'b1;
        end
        if (!we) begin
            if (ldr) hold_ldr = rd; else hold_core = rd;
        end
        exp_rd = ldr ? hold_ldr : hold_core;
        push(0, ldr, exp_rd, err, cyc + lat);
        wait_acks(0, 1);
        c0_req = 1'b0;
        l0_req = 1'b0;
    endtask

    initial begin
        int k;
        int ns;
        bar_rst = 1'b0;
        {c0_req, c0_we, l0_req, l0_we, c1_req, c1_we, l1_req, l1_we} = '0;
        {c0_addr, c0_wdata, l0_addr, l0_wdata} = '0;
        {c1_addr, c1_wdata, l1_addr, l1_wdata} = '0;
        hold_core = '0;
        hold_ldr  = '0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
        mem[1] = 16'h1111;
        mem[2] = 16'h2222;
        mem[5] = 16'h1234;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy0}, 0);
        chk("rst_store", {31'b0, m0_store}, 0);
        chk("rst_acks", {30'b0, c0_ack, l0_ack}, 0);
        chk("rst_errs", {30'b0, c0_err, l0_err}, 0);
        chk("rst_rdata", {c0_rdata, l0_rdata}, 0);
        chk("rst_mem", {m0_addr, m0_wdata}, 0);
        bar_rst = 1'b1;

        // Core read, loader write then read-back
        single(1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, 2);
        ns = n_store;
        single(1'b1, 1'b1, 16'h0003, 16'hBEEF, 16'h0000, 1'b0, 4);
        chk("wr_store_count", 32'(n_store - ns), 1);
        chk("wr_store_target", {st_addr, st_wdata}, {16'h0003, 16'hBEEF});
        single(1'b1, 1'b0, 16'h0003, 16'h0000, 16'hBEEF, 1'b0, 2);

        // Tie, round-robin: core wins first since the loader was granted last
        @(negedge clk);
        k = cyc;
        c0_we = 1'b0; c0_addr = 16'h0001; l0_we = 1'b0; l0_addr = 16'h0002;
        c0_req = 1'b1; l0_req = 1'b1;
        push(0, 1'b0, 16'h1111, 1'b0, k + 2);
        push(0, 1'b1, 16'h2222, 1'b0, k + 5);
        push(0, 1'b0, 16'h1111, 1'b0, k + 8);
        push(0, 1'b1, 16'h2222, 1'b0, k + 11);
        wait_acks(0, 4);
        c0_req = 1'b0; l0_req = 1'b0;
        hold_core = 16'h1111; hold_ldr = 16'h2222;

        // Tie, loader priority: loader every time
        @(negedge clk);
        k = cyc;
        c1_we = 1'b0; c1_addr = 16'h0001; l1_we = 1'b0; l1_addr = 16'h0002;
        c1_req = 1'b1; l1_req = 1'b1;
        for (int i = 0; i < 4; i++) push(1, 1'b1, 16'h2222, 1'b0, k + 2 + 3 * i);
        wait_acks(1, 4);
        c1_req = 1'b0; l1_req = 1'b0;

        // Unmapped address: write first so held read data can be seen untouched
        ns = n_store;
        single(1'b0, 1'b1, 16'hFFFF, 16'h5A5A, 16'h0000, 1'b1, 2);
        chk("unmapped_no_store", 32'(n_store - ns), 0);
        single(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 2);

        // Reset during the strobe cycle
        @(negedge clk);
        chk_store = 1'b0;
        l0_we = 1'b1; l0_addr = 16'h0004; l0_wdata = 16'h5555; l0_req = 1'b1;
        k = 0;
        for (int i = 0; i < 20 && k == 0; i++) begin
            @(negedge clk);
            if (m0_store) k = 1;
        end
        chk("rst_mid_reached_strobe", k, 1);
        #2 bar_rst = 1'b0;
        #1;
        chk("rst_mid_store", {31'b0, m0_store}, 0);
        chk("rst_mid_busy", {31'b0, busy0}, 0);
        l0_req = 1'b0;
        @(negedge clk);
        bar_rst = 1'b1;
        hold_core = '0; hold_ldr = '0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", {31'b0, busy0}, 0);
        chk_store = 1'b1;

        // Back-to-back core reads with REQ held across ACK
        @(negedge clk);
        k = cyc;
        c0_we = 1'b0; c0_addr = 16'h0001; c0_req = 1'b1;
        push(0, 1'b0, 16'h1111, 1'b0, k + 2);
        push(0, 1'b0, 16'h2222, 1'b0, k + 5);
        wait_acks(0, 1);
        c0_addr = 16'h0002;
        wait_acks(0, 1);
        c0_req = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
